// File: rtl/mul8_nibble_seq.sv
// mul8_nibble_seq: unsigned 8x8 multiply built from four passes through an external 4x4 multiplier.
// Operands are latched on acceptance; each STEP cycle adds one shifted nibble product into the accumulator.
module mul8_nibble_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [7:0]  i_in_a,
   input  logic [7:0]  i_in_b,
   output logic [3:0]  o_mul_a,
   output logic [3:0]  o_mul_b,
   input  logic [7:0]  i_mul_p,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [15:0] o_out_prod,
   output logic        o_busy
);
   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
   state_t      r_state, w_next;
   logic [1:0]  r_idx;
   logic [7:0]  r_a, r_b;
   logic [15:0] r_acc;
   logic        w_accept;
   logic [15:0] w_pp;
   assign w_accept = (r_state == IDLE) && i_in_valid;
   // idx0 -> shift 0, idx3 -> shift 8, the two cross terms -> shift 4
   assign w_pp = (r_idx == 2'd0) ? {8'h00, i_mul_p} :
                 (r_idx == 2'd3) ? {i_mul_p, 8'h00} : {4'h0, i_mul_p, 4'h0};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (i_in_valid ? STEP : IDLE) :
               (r_state == STEP) ? ((r_idx == 2'd3) ? DONE : STEP) :
               (i_out_ready ? IDLE : DONE);
   end
   always_comb begin
      o_in_ready  = (r_state == IDLE);
      o_busy      = (r_state != IDLE);
      o_out_valid = (r_state == DONE);
      o_out_prod  = r_acc;
      o_mul_a     = (r_state == STEP) ? (r_idx[0] ? r_a[7:4] : r_a[3:0]) : 4'h0;
      o_mul_b     = (r_state == STEP) ? (r_idx[1] ? r_b[7:4] : r_b[3:0]) : 4'h0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= 2'd0;
         r_a   <= 8'h00;
         r_b   <= 8'h00;
         r_acc <= 16'h0000;
      end else if (w_accept) begin
         r_idx <= 2'd0;
         r_a   <= i_in_a;
         r_b   <= i_in_b;
         r_acc <= 16'h0000;
      end else if (r_state == STEP) begin
         r_idx <= r_idx + 2'd1;
         r_acc <= r_acc + w_pp;
      end
   end
endmodule

// File: tb/tb_mul8_nibble_seq.sv
// tb_mul8_nibble_seq: scoreboard bench for the nibble-sequenced multiplier.
// Expected products come from plain a*b captured at acceptance; a monitor checks every DUT output cycle.
module tb_mul8_nibble_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [7:0]  i_in_a = 8'h00;
   logic [7:0]  i_in_b = 8'h00;
   logic [3:0]  o_mul_a, o_mul_b;
   logic [7:0]  w_mul_p;
   logic        o_out_valid;
   logic        i_out_ready = 1'b1;
   logic [15:0] o_out_prod;
   logic        o_busy;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] q[$];
   logic        rnd_bp = 1'b0;

   mul8_nibble_seq dut (
      .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_a(i_in_a), .i_in_b(i_in_b), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
      .i_mul_p(w_mul_p), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_prod(o_out_prod), .o_busy(o_busy)
   );

   // the external combinational 4x4 multiplier
   assign w_mul_p = {4'h0, o_mul_a} * {4'h0, o_mul_b};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rnd_bp) begin #1; i_out_ready = 1'($urandom_range(0, 1)); end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_in_ready"}, 32'(o_in_ready), 32'd1);
      chk({nm, "_out_valid"}, 32'(o_out_valid), 32'd0);
      chk({nm, "_busy"}, 32'(o_busy), 32'd0);
      chk({nm, "_out_prod"}, 32'(o_out_prod), 32'd0);
      chk({nm, "_mul"}, 32'({o_mul_a, o_mul_b}), 32'd0);
   endtask

   // monitor / scoreboard
   int          steps_left = 0;
   int          acc_cyc = 0;
   logic [7:0]  ca = 8'h00, cb = 8'h00;
   logic        prev_v = 1'b0, last_hs = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         steps_left = 0;
         prev_v = 1'b0;
         last_hs = 1'b0;
      end else begin
         if (last_hs) chk("ready_after_handshake", 32'(o_in_ready), 32'd1);
         last_hs = 1'b0;
         if (steps_left > 0) begin
            automatic int i = 4 - steps_left;
            automatic logic [3:0] ea = (i % 2 == 1) ? ca[7:4] : ca[3:0];
            automatic logic [3:0] eb = (i >= 2) ? cb[7:4] : cb[3:0];
            chk($sformatf("step%0d_mul", i), 32'({o_mul_a, o_mul_b}), 32'({ea, eb}));
            chk("step_flags", 32'({o_in_ready, o_busy, o_out_valid}), 32'b010);
            steps_left--;
         end else begin
            chk("mul_zero_outside_step", 32'({o_mul_a, o_mul_b}), 32'd0);
         end
         if (o_in_ready && i_in_valid) begin
            q.push_back(16'(i_in_a) * 16'(i_in_b));
            ca = i_in_a;
            cb = i_in_b;
            acc_cyc = cyc;
            steps_left = 4;
         end
         if (o_out_valid) begin
            if (!prev_v) chk("latency", 32'(cyc - acc_cyc), 32'd5);
            chk("done_flags", 32'({o_in_ready, o_busy}), 32'b01);
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               chk("out_prod", 32'(o_out_prod), 32'(q[0]));
               if (i_out_ready) begin
                  void'(q.pop_front());
                  last_hs = 1'b1;
               end
            end
         end
         prev_v = o_out_valid && !i_out_ready;
      end
   end

   task automatic wait_accept(output int at);
      bit ok = 1'b0;
      at = 0;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         if (o_in_ready) begin ok = 1'b1; at = cyc; end
      end
      if (!ok) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic req(input logic [7:0] a, input logic [7:0] b);
      int at;
      i_in_a = a;
      i_in_b = b;
      i_in_valid = 1'b1;
      wait_accept(at);
      i_in_valid = 1'b0;
      i_in_a = 8'($urandom);
      i_in_b = 8'($urandom);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !o_out_valid && !o_busy) ok = 1'b1;
      end
      if (!ok) chk("drain_timeout", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         if (o_out_valid) ok = 1'b1;
      end
      if (!ok) chk("valid_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int at, last;
      logic [7:0] pa[3] = '{8'h3C, 8'hE7, 8'h81};
      logic [7:0] pb[3] = '{8'h5D, 8'h02, 8'hFF};
      #12;
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      req(8'hFF, 8'hFF);
      drain();
      req(8'h12, 8'h34);
      drain();
      req(8'h00, 8'hAB);
      drain();
      req(8'hA5, 8'h3C);
      drain();
      // backpressure with a pending request
      i_out_ready = 1'b0;
      req(8'h77, 8'h99);
      i_in_a = 8'h5A;
      i_in_b = 8'hC3;
      i_in_valid = 1'b1;
      wait_valid();
      repeat (10) @(negedge clk);
      chk("bp_held_valid", 32'({o_out_valid, o_in_ready}), 32'b10);
      @(posedge clk); #1;
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_accept_after_hs", 32'({o_in_ready, o_busy}), 32'b10);
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      drain();
      // asynchronous reset in STEP idx2
      req(8'hC8, 8'h9B);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      req(8'h0F, 8'h0F);
      drain();
      // back-to-back with in_valid held high and operands disturbed during STEP
      last = 0;
      i_in_valid = 1'b1;
      for (int p = 0; p < 3; p++) begin
         i_in_a = pa[p];
         i_in_b = pb[p];
         wait_accept(at);
         if (p > 0) chk("b2b_spacing", 32'(at - last), 32'd6);
         last = at;
         repeat (2) begin
            i_in_a = 8'($urandom);
            i_in_b = 8'($urandom);
            @(posedge clk); #1;
         end
      end
      i_in_valid = 1'b0;
      drain();
      // randomized traffic with random backpressure
      rnd_bp = 1'b1;
      for (int n = 0; n < 30; n++) begin
         req(8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      rnd_bp = 1'b0;
      @(posedge clk); #2;
      i_out_ready = 1'b1;
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=done", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mul8_nibble_seq.md
Name: mul8_nibble_seq

Overview:
Sequencer that builds an unsigned 8x8 multiply from the team's existing combinational 4x4 array multiplier. It time-shares a single 4x4 multiplier instance across four nibble partial products and accumulates them into a 16-bit result. It sits between a valid/ready requester and the multiplier. The multiplier instance lives outside this block and connects through the mul_* ports.

Parameters:
none. Operand width is fixed at 8 bits (two nibbles) by the 4x4 multiplier.

Ports:
clk       input   1   single clock, all state on rising edge
rst_n     input   1   reset, asynchronous and active-low
in_valid  input   1   request valid
in_ready  output  1   block can accept a request
in_a      input   8   multiplicand, unsigned
in_b      input   8   multiplier, unsigned
mul_a     output  4   nibble to multiplier operand m
mul_b     output  4   nibble to multiplier operand q
mul_p     input   8   multiplier product, combinational from mul_a/mul_b
out_valid output  1   result valid
out_ready input   1   consumer accepts result
out_prod  output  16  in_a*in_b
busy      output  1   high in STEP or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, step index=0.
  - Operand registers and accumulator cleared.
  - out_valid=0, out_prod=0, busy=0, in_ready=1, mul_a=mul_b=0.
  - Reset mid-operation aborts it. No result is produced.
- States: IDLE, STEP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b, clear accumulator, idx=0, go to STEP.
  - Input changes after acceptance are ignored.
- STEP (4 cycles, idx 0..3): mul_a/mul_b are driven from the latched operands.
  - idx0: aL, bL; shift 0.
  - idx1: aH, bL; shift 4.
  - idx2: aL, bH; shift 4.
  - idx3: aH, bH; shift 8.
  - Each clock edge: acc <= acc + (mul_p << shift), zero-extended to 16 bits.
  - idx increments each cycle. After idx3 accumulates, go to DONE.
- No overflow is possible: max 255*255 = 0xFE01 < 2^16. Carries are not truncated.
- DONE:
  - out_valid=1, out_prod=acc.
  - out_prod is held stable while out_valid=1, regardless of out_ready.
  - On out_valid&out_ready: go to IDLE and drop out_valid.
- Outside STEP, mul_a=mul_b=0.
- out_prod keeps its last value in IDLE. It is cleared only when the next request is accepted, and on reset.
- in_ready=0 in STEP and DONE. Requests arriving then wait; in_valid held high is accepted on the first IDLE cycle.
- Latency:
  - Acceptance edge E; out_valid rises after edge E+4.
  - With out_ready=1, min request-to-request spacing is 6 cycles: accept, 4 steps, DONE handshake, next accept on the IDLE cycle after.
- busy = state != IDLE. All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to outputs, except through the state registers.
- Only the idx field of the STEP state advances. No other counters.

Test Plan:
- Accept in_a=0xFF, in_b=0xFF with out_ready=1 -> out_valid 4 cycles after acceptance, out_prod=0xFE01, then in_ready=1 on the following cycle.
- in_a=0x12, in_b=0x34 -> out_prod=0x03A8. Also check in_a=0x00, in_b=0xAB -> 0x0000.
- in_a=0xA5, in_b=0x3C: check the (mul_a, mul_b) sequence over the 4 STEP cycles -> (5,C), (A,C), (5,3), (A,3). Check out_prod=0x26AC. Check mul_a=mul_b=0 in IDLE/DONE.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_prod=result stable, in_ready=0, busy=1. A pending in_valid is not accepted. After out_ready=1 it is accepted one cycle after the handshake.
- Reset mid-op: assert rst_n=0 during STEP idx2 -> all outputs take their reset values immediately (asynchronously). After release, a new request 0x0F*0x0F gives 0x00E1 with no residue from the aborted operation.
- Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> 3 correct results in order, 6-cycle spacing. Change in_a/in_b during STEP -> result unaffected.
